prc_timing_ctrl: RTL
====================

PRC_TIMING_CTRL -- requirements
Module: prc_timing_ctrl

Interface
REQ-001 Parameter ADDR_BASE, default 24'h2080, 24-bit base address of the 12-byte register window (offsets 0x0-0xB).
REQ-002 Parameter COUNTER_W, default 7, width of the PRC counter.
REQ-003 Parameter COUNTER_MAX, default 65, counter saturation value; must be less than 2^COUNTER_W and no greater than 255.
REQ-004 Parameter PRESCALE_W, default 4, width of the rate prescaler; must be between 4 and 8.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle base-frame pulse (72 Hz equivalent).
REQ-008 cnt_tick  in  1  one-cycle counter-advance pulse.
REQ-009 cpu_write  in  1  register write strobe.
REQ-010 address_in  in  24  CPU byte address.
REQ-011 data_in  in  8  CPU write data.
REQ-012 data_out  out  8  register read data, combinational.
REQ-013 render_req  out  1  render request to the renderer, held until acknowledged.
REQ-014 render_ack  in  1  renderer accepts the request.
REQ-015 render_done  in  1  one-cycle pulse, render and copy finished.
REQ-016 irq_frame  out  1  one-cycle pulse on every divided frame event.
REQ-017 irq_copy  out  1  one-cycle pulse on render completion when copy is enabled.

Function
REQ-018 Register offsets: 0x0 mode[5:0]; 0x1 rate[7:0]; 0x2-0x4 map_base[20:3]; 0x5 scroll_y[6:0]; 0x6 scroll_x[6:0]; 0x7-0x9 sprite_base[20:3]; 0xA counter (read-only); 0xB status (overrun, bit0).
REQ-019 Write masks: 0x2/0x7 bits [7:3], 0x4/0x9 bits [4:0], 0x5/0x6 bits [6:0]; writes to 0xA, and to addresses outside the window, are ignored.
REQ-020 Reads return the addressed register zero-extended; 0x7-0x9 return sprite_base; rate reads as {prescaler, rate[3:0]}; reads outside the window return 0.
REQ-021 A rate write whose bits [3:1] differ from the current value clears the prescaler; otherwise the prescaler is preserved.
REQ-022 Divider match value by rate[3:1]: 0->2, 1->5, 2->8, 3->11, 4->1, 5->3, 6->5, 7->7.
REQ-023 When rate[0]=1 and frame_tick=1, the prescaler increments; when it equals the match value, it returns to 0 instead and a frame event occurs in that cycle.
REQ-024 When rate[0]=0, the prescaler holds and no frame events occur.
REQ-025 If a rate write and frame_tick coincide, the write takes effect, the prescaler follows REQ-021, and no increment occurs.
REQ-026 Every frame event pulses irq_frame for one cycle, registered, in the following cycle.
REQ-027 FSM states: IDLE, REQ, BUSY.
REQ-028 IDLE->REQ on a frame event when mode[3:1]!=0; otherwise the FSM stays in IDLE.
REQ-029 render_req is 1 only in REQ; REQ->BUSY on the cycle render_ack=1 is sampled.
REQ-030 BUSY->IDLE on render_done=1; irq_copy pulses in the next cycle if mode[3]=1.
REQ-031 The counter clears to 0 on IDLE->REQ, increments on each cnt_tick while in BUSY, saturates at COUNTER_MAX, and holds in IDLE.
REQ-032 A frame event while in REQ or BUSY, including the BUSY->IDLE cycle, is dropped.
REQ-033 render_ack or render_done received outside REQ or BUSY respectively is ignored.

Reset
REQ-034 While reset_n=0: all registers, the prescaler and the counter are 0, the FSM is IDLE, and render_req, irq_frame and irq_copy are 0.
REQ-035 Reset asserted mid-handshake aborts it immediately; render_req deasserts asynchronously.

Configuration
REQ-036 With PRC_OVERRUN_STATUS_EN defined: a dropped frame event sets status bit0, and writing 1 to bit0 clears it; if a set and a clear coincide, the set wins.
REQ-037 Without PRC_OVERRUN_STATUS_EN defined: offset 0xB reads 0, writes to it are ignored, and drops are silent.

Verification
REQ-038 Scenario 1: rate=0x01, 3 frame_ticks -> one irq_frame pulse after the 3rd; prescaler reads 0.
REQ-039 Scenario 2: prescaler=2 at rate=0x0B, then write rate=0x03 -> rate reads 0x03; then write rate=0x02 -> prescaler is preserved.
REQ-040 Scenario 3: mode=0x08, event, ack after 4 cycles, 70 cnt_ticks, then done -> counter reads 65 and irq_copy pulses once.
REQ-041 Scenario 4: frame event during BUSY -> no new render_req; status reads 0x01; writing 0x01 to 0xB clears it.
REQ-042 Scenario 5: reset_n low while in REQ -> render_req falls immediately; all registers read 0.
REQ-043 Scenario 6: write sprite_base = 0x12_3456 -> offsets 0x7/0x8/0x9 read 0x50/0x34/0x12; map_base is unchanged.

Source files
------------

// File: rtl/prc_timing_ctrl.sv
// PRC timing controller: CPU register window, frame-rate divider and render handshake FSM.
// Optional build macro PRC_OVERRUN_STATUS_EN enables the sticky overrun bit at offset 0xB.
module prc_timing_ctrl #(
  parameter logic [23:0] ADDR_BASE   = 24'h2080,
  parameter int          COUNTER_W   = 7,
  parameter int          COUNTER_MAX = 65,
  parameter int          PRESCALE_W  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        cnt_tick,
  input  logic        cpu_write,
  input  logic [23:0] address_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        render_req,
  input  logic        render_ack,
  input  logic        render_done,
  output logic        irq_frame,
  output logic        irq_copy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t                state_q;
  logic [5:0]            mode_q;
  logic [3:0]            rate_q;
  logic [4:0]            map_lo_q;
  logic [7:0]            map_mid_q;
  logic [4:0]            map_hi_q;
  logic [6:0]            scroll_y_q;
  logic [6:0]            scroll_x_q;
  logic [4:0]            spr_lo_q;
  logic [7:0]            spr_mid_q;
  logic [4:0]            spr_hi_q;
  logic [PRESCALE_W-1:0] prescaler_q;
  logic [COUNTER_W-1:0]  counter_q;
  logic                  status_bit;

  logic [23:0] offset_full;
  logic        in_window;
  logic [3:0]  off;
  logic        wr;
  logic        rate_wr;
  logic [3:0]  match_val;
  logic        frame_event;

  assign offset_full = address_in - ADDR_BASE;
  assign in_window   = offset_full < 24'd12;
  assign off         = offset_full[3:0];
  assign wr          = cpu_write && in_window;
  assign rate_wr     = wr && (off == 4'h1);
  assign dbg_state   = state_q;

  always_comb begin
    match_val = 4'd2;
    case (rate_q[3:1])
      3'd0: match_val = 4'd2;
      3'd1: match_val = 4'd5;
      3'd2: match_val = 4'd8;
      3'd3: match_val = 4'd11;
      3'd4: match_val = 4'd1;
      3'd5: match_val = 4'd3;
      3'd6: match_val = 4'd5;
      3'd7: match_val = 4'd7;
      default: match_val = 4'd2;
    endcase
  end

  // A rate write in the same cycle as frame_tick suppresses the tick.
  assign frame_event = rate_q[0] && frame_tick && !rate_wr &&
                       (prescaler_q == PRESCALE_W'(match_val));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= '0;
      rate_q      <= '0;
      map_lo_q    <= '0;
      map_mid_q   <= '0;
      map_hi_q    <= '0;
      scroll_y_q  <= '0;
      scroll_x_q  <= '0;
      spr_lo_q    <= '0;
      spr_mid_q   <= '0;
      spr_hi_q    <= '0;
      prescaler_q <= '0;
    end else begin
      if (wr) begin
        case (off)
          4'h0: mode_q     <= data_in[5:0];
          4'h1: rate_q     <= data_in[3:0];
          4'h2: map_lo_q   <= data_in[7:3];
          4'h3: map_mid_q  <= data_in;
          4'h4: map_hi_q   <= data_in[4:0];
          4'h5: scroll_y_q <= data_in[6:0];
          4'h6: scroll_x_q <= data_in[6:0];
          4'h7: spr_lo_q   <= data_in[7:3];
          4'h8: spr_mid_q  <= data_in;
          4'h9: spr_hi_q   <= data_in[4:0];
          default: ;
        endcase
      end
      if (rate_wr) begin
        if (data_in[3:1] != rate_q[3:1]) prescaler_q <= '0;
      end else if (rate_q[0] && frame_tick) begin
        prescaler_q <= frame_event ? '0 : prescaler_q + 1'b1;
      end
    end
  end

`ifdef PRC_OVERRUN_STATUS_EN
  logic frame_drop;
  assign frame_drop = frame_event && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_bit <= 1'b0;
    end else if (frame_drop) begin
      status_bit <= 1'b1;
    end else if (wr && (off == 4'hB) && data_in[0]) begin
      status_bit <= 1'b0;
    end
  end
`else
  assign status_bit = 1'b0;
`endif

  // Handshake: render_req is held high in REQ until render_ack is sampled high
  // on a rising edge; render_done is honoured only in BUSY, render_ack only in REQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      render_req <= 1'b0;
      irq_frame  <= 1'b0;
      irq_copy   <= 1'b0;
      counter_q  <= '0;
    end else begin
      irq_frame <= frame_event;
      irq_copy  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_event && (mode_q[3:1] != 3'd0)) begin
            state_q    <= S_REQ;
            render_req <= 1'b1;
            counter_q  <= '0;
          end
        end
        S_REQ: begin
          if (render_ack) begin
            state_q    <= S_BUSY;
            render_req <= 1'b0;
          end
        end
        S_BUSY: begin
          if (cnt_tick && (counter_q != COUNTER_W'(COUNTER_MAX)))
            counter_q <= counter_q + 1'b1;
          if (render_done) begin
            state_q  <= S_IDLE;
            irq_copy <= mode_q[3];
          end
        end
        default: begin
          state_q    <= S_IDLE;
          render_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (in_window) begin
      case (off)
        4'h0: data_out = {2'b00, mode_q};
        4'h1: data_out = {prescaler_q[3:0], rate_q};
        4'h2: data_out = {map_lo_q, 3'b000};
        4'h3: data_out = map_mid_q;
        4'h4: data_out = {3'b000, map_hi_q};
        4'h5: data_out = {1'b0, scroll_y_q};
        4'h6: data_out = {1'b0, scroll_x_q};
        4'h7: data_out = {spr_lo_q, 3'b000};
        4'h8: data_out = spr_mid_q;
        4'h9: data_out = {3'b000, spr_hi_q};
        4'hA: data_out = 8'(counter_q);
        4'hB: data_out = {7'b0000000, status_bit};
        default: data_out = 8'h00;
      endcase
    end
  end

endmodule
